// File: rtl/output_delta_if.sv
// rtl/output_delta_if.sv - request/result bundle for the output-layer delta engine
interface output_delta_if;
  logic        start;
  logic [31:0] a3_1;
  logic [31:0] a3_2;
  logic [31:0] t_1;
  logic [31:0] t_2;
  logic [31:0] delta3_1;
  logic [31:0] delta3_2;
  logic        busy;
  logic        done;

  modport master (
    output start, a3_1, a3_2, t_1, t_2,
    input  delta3_1, delta3_2, busy, done
  );

  modport slave (
    input  start, a3_1, a3_2, t_1, t_2,
    output delta3_1, delta3_2, busy, done
  );
endinterface

// File: rtl/output_delta.sv
// rtl/output_delta.sv - Q8.24 output-layer deltas (a-t)*a*(1-a) on one shared multiplier
// Optional feature: define OUTPUT_DELTA_SAT_EN to clamp subtractions and product slices.
module output_delta (
  input  logic          clk,
  input  logic          reset,
  output_delta_if.slave bus
);

  localparam logic [31:0] Q_ONE = 32'h0100_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    D1   = 3'd2,
    P2   = 3'd3,
    D2   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [31:0] a1_r;
  logic [31:0] a2_r;
  logic [31:0] t1_r;
  logic [31:0] t2_r;
  logic [31:0] p_r;
  logic [31:0] d1_r;
  logic [31:0] out1_r;
  logic [31:0] out2_r;

  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic signed [63:0] ext_a;
  logic signed [63:0] ext_b;
  logic signed [63:0] prod;
  logic [31:0]        prod_q;
  logic               busy_c;
  logic               done_c;

  function automatic logic [31:0] sub_q(input logic [31:0] x, input logic [31:0] y);
`ifdef OUTPUT_DELTA_SAT_EN
    logic [32:0] w;
    w = {x[31], x} - {y[31], y};
    if (w[32] != w[31])
      sub_q = w[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      sub_q = w[31:0];
`else
    sub_q = x - y;
`endif
  endfunction

  // Keep bits [55:24]; dropping the low bits of a two's-complement value floors it.
  function automatic logic [31:0] slice_q(input logic signed [63:0] p);
`ifdef OUTPUT_DELTA_SAT_EN
    if (p[63:55] != {9{p[63]}})
      slice_q = p[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      slice_q = p[55:24];
`else
    slice_q = p[55:24];
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start)
          state_nxt = P1;
      end
      P1:  state_nxt = D1;
      D1:  state_nxt = P2;
      P2:  state_nxt = D2;
      D2:  state_nxt = FIN;
      FIN: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand steering for the single time-shared multiplier.
  always_comb begin
    mul_a = 32'h0;
    mul_b = 32'h0;
    case (state)
      P1: begin
        mul_a = a1_r;
        mul_b = sub_q(Q_ONE, a1_r);
      end
      D1: begin
        mul_a = sub_q(a1_r, t1_r);
        mul_b = p_r;
      end
      P2: begin
        mul_a = a2_r;
        mul_b = sub_q(Q_ONE, a2_r);
      end
      D2: begin
        mul_a = sub_q(a2_r, t2_r);
        mul_b = p_r;
      end
      default: begin
        mul_a = 32'h0;
        mul_b = 32'h0;
      end
    endcase
  end

  assign ext_a  = {{32{mul_a[31]}}, mul_a};
  assign ext_b  = {{32{mul_b[31]}}, mul_b};
  assign prod   = ext_a * ext_b;
  assign prod_q = slice_q(prod);

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_r   <= 32'h0;
      a2_r   <= 32'h0;
      t1_r   <= 32'h0;
      t2_r   <= 32'h0;
      p_r    <= 32'h0;
      d1_r   <= 32'h0;
      out1_r <= 32'h0;
      out2_r <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a1_r <= bus.a3_1;
            a2_r <= bus.a3_2;
            t1_r <= bus.t_1;
            t2_r <= bus.t_2;
          end
        end
        P1: p_r  <= prod_q;
        D1: d1_r <= prod_q;
        P2: p_r  <= prod_q;
        // Both outputs change together on the edge into FIN.
        D2: begin
          out1_r <= d1_r;
          out2_r <= prod_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.delta3_1 = out1_r;
  assign bus.delta3_2 = out2_r;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;

endmodule

// File: tb/tb_output_delta.sv
// tb/tb_output_delta.sv - vector table, corner sequences and random ops against a Q8.24 model
module tb_output_delta;

  localparam logic [31:0] Q_ONE = 32'h0100_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  output_delta_if bus();

  output_delta dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a1;
    logic [31:0] t1;
    logic [31:0] a2;
    logic [31:0] t2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_fit(input longint v);
`ifdef OUTPUT_DELTA_SAT_EN
    longint hi;
    longint lo;
    hi = (longint'(1) <<< 31) - 1;
    lo = -(longint'(1) <<< 31);
    if (v > hi) return 32'h7FFF_FFFF;
    if (v < lo) return 32'h8000_0000;
`endif
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_sub(input logic [31:0] x, input logic [31:0] y);
    return m_fit(longint'($signed(x)) - longint'($signed(y)));
  endfunction

  function automatic logic [31:0] m_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return m_fit(p >>> 24);
  endfunction

  function automatic logic [31:0] m_delta(input logic [31:0] a, input logic [31:0] t);
    return m_mul(m_sub(a, t), m_mul(a, m_sub(Q_ONE, a)));
  endfunction

  task automatic set_ops(input logic [31:0] a1, input logic [31:0] t1,
                         input logic [31:0] a2, input logic [31:0] t2);
    bus.a3_1 = a1;
    bus.t_1  = t1;
    bus.a3_2 = a2;
    bus.t_2  = t2;
  endtask

  // Issues one start and follows it to done; lat counts observed cycles P1..FIN.
  task automatic run_op(input logic [31:0] a1, input logic [31:0] t1,
                        input logic [31:0] a2, input logic [31:0] t2,
                        input bit scramble,
                        output logic [31:0] d1, output logic [31:0] d2,
                        output int lat, output int busy_cnt);
    set_ops(a1, t1, a2, t2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (scramble) begin
      bus.a3_1 = 32'h0;
      bus.t_1  = 32'h0;
    end
    lat = -1;
    busy_cnt = 0;
    d1 = 32'hDEAD_BEEF;
    d2 = 32'hDEAD_BEEF;
    for (int i = 1; i <= 20; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = i;
        d1 = bus.delta3_1;
        d2 = bus.delta3_2;
        break;
      end
      step();
    end
    step();
  endtask

  initial begin
    logic [31:0] g1, g2, h1, h2, ra1, rt1, ra2, rt2;
    int lat, bc, npulse, first_at, second_at;

    vecs[0] = '{32'h00C0_0000, 32'h0100_0000, 32'h0080_0000, 32'h0000_0000, 32'hFFF4_0000, 32'h0020_0000};
    vecs[1] = '{32'h00C2_9999, 32'h00C2_9999, 32'h00C2_9999, 32'h00C2_9999, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{32'h0100_0000, 32'h0000_0000, 32'h0100_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
`ifdef OUTPUT_DELTA_SAT_EN
    vecs[3] = '{32'h1000_0000, 32'h0000_0000, 32'h0080_0000, 32'h0000_0000, 32'h8000_0000, 32'h0020_0000};
    vecs[4] = '{32'h00C0_0000, 32'h0100_0000, 32'h1000_0000, 32'h0000_0000, 32'hFFF4_0000, 32'h8000_0000};
`else
    vecs[3] = '{32'h1000_0000, 32'h0000_0000, 32'h0080_0000, 32'h0000_0000, 32'h0000_0000, 32'h0020_0000};
    vecs[4] = '{32'h00C0_0000, 32'h0100_0000, 32'h1000_0000, 32'h0000_0000, 32'hFFF4_0000, 32'h0000_0000};
`endif

    bus.start = 1'b0;
    set_ops(32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b1;
    step();
    step();
    chk("reset_delta1", bus.delta3_1, 32'h0);
    chk("reset_delta2", bus.delta3_2, 32'h0);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_done", {31'h0, bus.done}, 32'h0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      run_op(vecs[v].a1, vecs[v].t1, vecs[v].a2, vecs[v].t2, 1'b0, g1, g2, lat, bc);
      chk($sformatf("vec%0d_delta1", v), g1, vecs[v].e1);
      chk($sformatf("vec%0d_delta2", v), g2, vecs[v].e2);
      chk($sformatf("vec%0d_latency", v), lat, 5);
      chk($sformatf("vec%0d_busy_cycles", v), bc, 5);
      chk($sformatf("vec%0d_idle_after", v), {30'h0, bus.busy, bus.done}, 32'h0);
    end

    for (int i = 0; i < 3; i++) step();
    chk("hold_delta1", bus.delta3_1, vecs[4].e1);
    chk("hold_delta2", bus.delta3_2, vecs[4].e2);

    run_op(vecs[0].a1, vecs[0].t1, vecs[0].a2, vecs[0].t2, 1'b1, g1, g2, lat, bc);
    chk("latch_delta1", g1, 32'hFFF4_0000);
    chk("latch_delta2", g2, 32'h0020_0000);

    set_ops(vecs[0].a1, vecs[0].t1, vecs[0].a2, vecs[0].t2);
    bus.start = 1'b1;
    npulse = 0;
    first_at = -1;
    second_at = -1;
    h1 = 32'h0;
    h2 = 32'h0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) begin
        npulse++;
        if (npulse == 1) first_at = i;
        if (npulse == 2) begin
          second_at = i;
          h1 = bus.delta3_1;
          h2 = bus.delta3_2;
        end
      end
    end
    bus.start = 1'b0;
    step();
    step();
    chk("held_start_pulses", npulse, 2);
    chk("held_start_spacing", second_at - first_at, 6);
    chk("held_start_first_at", first_at, 4);
    chk("held_start_delta1", h1, 32'hFFF4_0000);
    chk("held_start_delta2", h2, 32'h0020_0000);

    set_ops(vecs[0].a1, vecs[0].t1, vecs[0].a2, vecs[0].t2);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("abort_busy_in_d1", {31'h0, bus.busy}, 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_delta1", bus.delta3_1, 32'h0);
    chk("abort_delta2", bus.delta3_2, 32'h0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done) npulse++;
    end
    chk("abort_no_done", npulse, 0);
    run_op(vecs[0].a1, vecs[0].t1, vecs[0].a2, vecs[0].t2, 1'b0, g1, g2, lat, bc);
    chk("post_abort_delta1", g1, 32'hFFF4_0000);
    chk("post_abort_delta2", g2, 32'h0020_0000);
    chk("post_abort_latency", lat, 5);

    reset = 1'b1;
    bus.start = 1'b1;
    step();
    reset = 1'b0;
    bus.start = 1'b0;
    chk("reset_over_start_busy", {31'h0, bus.busy}, 32'h0);
    step();
    chk("reset_over_start_idle", {31'h0, bus.busy}, 32'h0);

    for (int r = 0; r < 40; r++) begin
      if (r % 2 == 0) begin
        ra1 = $urandom_range(32'h0200_0000, 0) - 32'h0100_0000;
        rt1 = $urandom_range(32'h0200_0000, 0) - 32'h0100_0000;
        ra2 = $urandom_range(32'h0200_0000, 0) - 32'h0100_0000;
        rt2 = $urandom_range(32'h0200_0000, 0) - 32'h0100_0000;
      end else begin
        ra1 = $urandom;
        rt1 = $urandom;
        ra2 = $urandom;
        rt2 = $urandom;
      end
      run_op(ra1, rt1, ra2, rt2, 1'b0, g1, g2, lat, bc);
      chk($sformatf("rand%0d_delta1 a=%08h t=%08h", r, ra1, rt1), g1, m_delta(ra1, rt1));
      chk($sformatf("rand%0d_delta2 a=%08h t=%08h", r, ra2, rt2), g2, m_delta(ra2, rt2));
      chk($sformatf("rand%0d_latency", r), lat, 5);
      for (int k = 0; k < int'($urandom_range(2, 0)); k++) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_delta.md
OUTPUT_DELTA -- requirements
Module: output_delta

Interface
REQ-001: clk  input  1  rising-edge clock; all state changes on this edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-003: start  input  1  one-cycle request to compute output-layer deltas from the current a3/t inputs.
REQ-004: a3_1, a3_2  input  32 each  signed Q8.24 output-layer activations from the forward stage.
REQ-005: t_1, t_2  input  32 each  signed Q8.24 training targets.
REQ-006: delta3_1, delta3_2  output  32 each  signed Q8.24 deltas: (a3_k - t_k) * a3_k * (1 - a3_k).
REQ-007: busy  output  1  high while a computation is in progress.
REQ-008: done  output  1  one-cycle pulse; deltas are valid and updated in this cycle.

Function
REQ-009: The block shall use exactly one 32x32 signed multiplier, time-shared across all products.
REQ-010: FSM states are IDLE, P1, D1, P2, D2 and FIN.
- IDLE -> P1 on start.
- P1 -> D1 -> P2 -> D2 -> FIN unconditionally.
- FIN -> IDLE.
REQ-011: In IDLE with start=1, the block shall latch a3_1, a3_2, t_1 and t_2 on that edge; later input changes shall not affect the result.
REQ-012: P_k shall compute p_k = a_k * (0x01000000 - a_k); D_k shall compute delta_k = (a_k - t_k) * p_k, with each result registered at the end of its state.
REQ-013: Multiply: the block shall form the full 64-bit signed product and take bits [55:24], truncating toward minus infinity with no rounding.
REQ-014: Without saturation (see REQ-026), subtraction and product-slice overflow shall wrap modulo 2^32.
REQ-015: delta3_1 and delta3_2 shall both update on the edge that enters FIN; done=1 only while in FIN.
REQ-016: Latency: start sampled at edge N gives done high in the cycle after edge N+4, which is 5 clocks from start to done.
REQ-017: busy=1 in P1..FIN and 0 in IDLE.
REQ-018: start asserted while busy=1 shall be ignored, not queued.
REQ-019: start asserted in the cycle after FIN (IDLE again) shall be accepted, giving back-to-back operation every 6 cycles.
REQ-020: Between operations, delta3_x shall hold their last values.

Reset
REQ-021: With reset=1 at a clock edge, the state shall go to IDLE and delta3_1, delta3_2, busy and done shall all be 0.
REQ-022: Reset shall also clear all internal latched operands and partial products.
REQ-023: Reset shall take priority over start in the same cycle.
REQ-024: Reset mid-operation (any state P1..FIN) shall abort with no done pulse, and outputs shall read 0.
REQ-025: After reset deasserts, the first start shall be accepted in IDLE.

Configuration
REQ-026: Macro OUTPUT_DELTA_SAT_EN shall select saturation.
- Defined: each subtraction and each product slice that exceeds the Q8.24 range shall clamp to 0x7FFFFFFF (positive) or 0x80000000 (negative).
- Not defined: arithmetic wraps per REQ-014.
- Latency and handshake are identical in both builds.

Verification
REQ-027: reset, then start with a3_1=0x00C00000 (0.75), t_1=0x01000000 (1.0), a3_2=0x00800000 (0.5), t_2=0x00000000 -> done 5 clocks later; delta3_1=0xFFF40000 (-0.046875), delta3_2=0x00200000 (0.125); busy high for 5 cycles.
REQ-028: hold start high for 12 cycles with the REQ-027 operands -> exactly two done pulses, 6 cycles apart, each with the same results; starts during busy are ignored.
REQ-029: start, then change a3_1/t_1 to 0 on the next cycle -> results still equal REQ-027 values.
REQ-030: a3_1=0x10000000 (16.0), t_1=0 -> with OUTPUT_DELTA_SAT_EN: delta3_1=0x80000000; without it: delta3_1=0x00000000.
REQ-031: assert reset while in D1 -> no done pulse, delta3_x=0, busy=0; a following start with REQ-027 operands gives correct results.
REQ-032: a3_k=t_k=0x00C29999 -> delta3_k=0x00000000; a3_k=0x01000000 with t_k=0 -> delta3_k=0x00000000.
